// File: rtl/alu_writeback.sv
// ALU result writeback: selects the opcode's result, writes it to the register file
// (two halves for a 32-bit multiply), keeps zero/negative flags and an illegal-op counter.
module alu_writeback #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5:0]           select,
    input  logic [5:0]           rdst,
    input  logic [15:0]          sum,
    input  logic [15:0]          diff,
    input  logic [15:0]          negate,
    input  logic [15:0]          divi,
    input  logic [15:0]          or_gat,
    input  logic [15:0]          xor_gat,
    input  logic [15:0]          nand_gat,
    input  logic [15:0]          nor_gat,
    input  logic [15:0]          xnor_gat,
    input  logic [15:0]          not_gat,
    input  logic [15:0]          left_sft,
    input  logic [15:0]          right_sft,
    input  logic [31:0]          multiplied,
    output logic                 wr_en,
    output logic [5:0]           wr_addr,
    output logic [15:0]          wr_data,
    output logic                 flag_z,
    output logic                 flag_n,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [5:0] OP_MUL = 6'd3;

    typedef enum logic [1:0] {
        IDLE,
        WR_LO,
        WR_HI
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] result_sel;
    logic        legal_sel;
    logic        xfer;
    logic [31:0] result_p1;
    logic [5:0]  rdst_p1;
    logic [5:0]  op_p1;
    logic        is_mul_p1;
    logic        zero_p1;
    logic        neg_p1;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign in_ready = (state == IDLE);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        result_sel = '0;
        legal_sel  = 1'b1;
        case (select)
            6'd0:    result_sel = {16'h0000, sum};
            6'd1:    result_sel = {16'h0000, diff};
            6'd2:    result_sel = {16'h0000, negate};
            6'd3:    result_sel = multiplied;
            6'd4:    result_sel = {16'h0000, divi};
            6'd5:    result_sel = {16'h0000, or_gat};
            6'd6:    result_sel = {16'h0000, xor_gat};
            6'd7:    result_sel = {16'h0000, nand_gat};
            6'd8:    result_sel = {16'h0000, nor_gat};
            6'd9:    result_sel = {16'h0000, xnor_gat};
            6'd10:   result_sel = {16'h0000, not_gat};
            6'd11:   result_sel = {16'h0000, left_sft};
            6'd12:   result_sel = {16'h0000, right_sft};
            default: legal_sel  = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer && legal_sel) state_nxt = WR_LO;
            WR_LO:   state_nxt = is_mul_p1 ? WR_HI : IDLE;
            WR_HI:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Write port is a pure decode of the registered state, so reset clears it at once
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state)
            WR_LO: begin
                wr_en   = 1'b1;
                wr_addr = rdst_p1;
                wr_data = result_p1[15:0];
            end
            WR_HI: begin
                wr_en   = 1'b1;
                wr_addr = rdst_p1 + 6'd1;
                wr_data = result_p1[31:16];
            end
            default: ;
        endcase
    end

    assign is_mul_p1 = (op_p1 == OP_MUL);
    assign zero_p1   = is_mul_p1 ? (result_p1 == 32'h0) : (result_p1[15:0] == 16'h0);
    assign neg_p1    = is_mul_p1 ? result_p1[31] : result_p1[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            result_p1 <= '0;
            rdst_p1   <= '0;
            op_p1     <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                result_p1 <= result_sel;
                rdst_p1   <= rdst;
                op_p1     <= select;
            end
            if (xfer && !legal_sel) begin
                err_cnt <= sat_inc(err_cnt);
            end
            if (state == WR_LO) begin
                flag_z <= zero_p1;
                flag_n <= neg_p1;
            end
        end
    end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter ERR_CNT_W, default 8, width of the saturating illegal-opcode counter.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  ALU result bundle valid.
REQ-005 in_ready  output  1  block can accept bundle; high only in state IDLE (combinational from state).
REQ-006 select  input  6  ALU opcode (instruction bits 31:26).
REQ-007 rdst  input  6  destination register address.
REQ-008 sum, diff, negate, divi, or_gat, xor_gat, nand_gat, nor_gat, xnor_gat, not_gat, left_sft, right_sft  input  16 each  ALU candidate results.
REQ-009 multiplied  input  32  ALU product.
REQ-010 wr_en  output  1  register-file write strobe.
REQ-011 wr_addr  output  6  register-file write address.
REQ-012 wr_data  output  16  register-file write data.
REQ-013 flag_z, flag_n  output  1 each  zero / negative flags of last completed legal op.
REQ-014 err_cnt  output  ERR_CNT_W  count of illegal opcodes accepted.

Function
REQ-015 Opcode map SHALL be: 0 sum, 1 diff, 2 negate, 3 multiplied, 4 divi, 5 or, 6 xor, 7 nand, 8 nor, 9 xnor, 10 not, 11 left_sft, 12 right_sft; 13..63 illegal.
REQ-016 Transfer SHALL occur on a rising edge with in_valid && in_ready; on transfer the selected result (32-bit for op 3, else 16-bit zero-extended), rdst and op SHALL be registered.
REQ-017 FSM states SHALL be IDLE, WR_LO, WR_HI.
REQ-018 IDLE: on transfer of legal op -> WR_LO; on transfer of illegal op -> stay IDLE, err_cnt increments, no write; no transfer -> stay IDLE.
REQ-019 WR_LO: wr_en=1, wr_addr=rdst_q, wr_data=result_q[15:0]; next edge -> WR_HI if op 3, else IDLE.
REQ-020 WR_HI: wr_en=1, wr_addr=(rdst_q+1) mod 64 (63 wraps to 0), wr_data=result_q[31:16]; next edge -> IDLE.
REQ-021 wr_en, wr_addr, wr_data SHALL be decoded from registered state only; wr_en=0, wr_addr=0, wr_data=0 in IDLE.
REQ-022 Latency: data written in the cycle immediately after the accepting edge; throughput one op per 2 cycles, multiply one per 3 cycles.
REQ-023 in_valid while in_ready=0 SHALL be ignored; upstream holds bundle until accepted.
REQ-024 Flags SHALL update on the edge leaving WR_LO: flag_z = (result_q==0) over 32 bits for op 3, 16 bits otherwise; flag_n = MSB (bit 31 for op 3, bit 15 otherwise).
REQ-025 Illegal ops SHALL NOT change flags.
REQ-026 err_cnt SHALL saturate at 2^ERR_CNT_W-1, never wrap.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, wr_en=0, wr_addr=0, wr_data=0, flag_z=0, flag_n=0, err_cnt=0, captured registers 0, independent of clk.
REQ-028 Reset during WR_LO or WR_HI SHALL abort the op; no write strobe after rst_n asserts; pending high-half write is dropped.
REQ-029 After rst_n deasserts, in_ready=1 in the first cycle; first transfer possible on the first rising edge.

Verification
REQ-030 op 0, rdst=5, sum=16'h1234, in_valid 1 cycle -> next cycle wr_en=1, wr_addr=5, wr_data=16'h1234; flag_z=0, flag_n=0; back in IDLE one cycle later.
REQ-031 op 3, rdst=63, multiplied=32'h8000_0001 -> cycle1 addr 63 data 16'h0001, cycle2 addr 0 data 16'h8000; flag_n=1, flag_z=0; in_ready low both cycles.
REQ-032 op 1, diff=0 -> single write data 0, flag_z=1, flag_n=0; then op 40 -> no wr_en, err_cnt=1, flags unchanged.
REQ-033 in_valid held high continuously with ops 0,3,0 -> writes in cycles 1,3,4,6 pattern (2/3/2-cycle spacing), no bundle lost or duplicated.
REQ-034 rst_n pulsed low mid-WR_LO of op 3 -> wr_en drops asynchronously, no WR_HI write, all outputs 0, in_ready=1 after release.
REQ-035 ERR_CNT_W=2, five illegal ops -> err_cnt 1,2,3,3,3.
